// File: rtl/fifo_read_stream.sv
// Read-side consumer for async_fifo: pops words and re-presents them as a valid/ready
// stream through a 3-entry circular skid buffer, with synchronous flush and a transfer counter.
module fifo_read_stream #(
    parameter int BITS     = 32,
    parameter int CNT_BITS = 16
) (
    input  logic                read_clk,
    input  logic                read_rst_n,
    output logic                p_read_en,
    input  logic [BITS-1:0]     p_read_data,
    input  logic                p_read_empty,
    input  logic                flush,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BITS-1:0]     m_data,
    output logic [1:0]          occupancy,
    output logic [CNT_BITS-1:0] word_count
);

    logic [1:0]          occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          wr_ptr_q, wr_ptr_d;
    logic [1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic [BITS-1:0]     buf_q [3];
    logic [2:0]          credit;
    logic                capture;
    logic                transfer;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Held plus in-flight words bound the pops, so a capture always finds a free slot.
    assign credit     = {1'b0, occ_q} + {2'b00, inflight_q};
    assign p_read_en  = read_rst_n && !p_read_empty && !flush && (credit < 3'd3);
    assign m_valid    = (occ_q != 2'd0) && !flush;
    assign m_data     = buf_q[rd_ptr_q];
    assign capture    = inflight_q && !flush;
    assign transfer   = m_valid && m_ready;
    assign occupancy  = occ_q;
    assign word_count = count_q;

    always_comb begin
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = p_read_en;
        if (flush) begin
            occ_d    = 2'd0;
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
        end else begin
            if (capture) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (transfer) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_q + CNT_BITS'(1);
            end
            case ({capture, transfer})
                2'b10:   occ_d = occ_q + 2'd1;
                2'b01:   occ_d = occ_q - 2'd1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (capture) begin
                buf_q[wr_ptr_q] <= p_read_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a FIFO model feeds the DUT and a queue-based reference of
// popped-but-not-delivered words predicts every stream output.
module tb_fifo_read_stream;

    localparam int BITS = 32;
    localparam int CNT  = 4;

    logic            read_clk;
    logic            read_rst_n;
    logic            p_read_en;
    logic [BITS-1:0] p_read_data = '0;
    logic            p_read_empty;
    logic            flush;
    logic            m_valid;
    logic            m_ready;
    logic [BITS-1:0] m_data;
    logic [1:0]      occupancy;
    logic [CNT-1:0]  word_count;

    logic            stall;
    logic [BITS-1:0] mem [1024];
    int              head = 0;
    int              tail = 0;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int cnt    = 0;

    // Each word leaves the FIFO at a pop edge and becomes visible to the sink one edge later.
    typedef struct {
        logic [BITS-1:0] d;
        int              vis;
    } ent_t;
    ent_t mq[$];

    logic            s_pop;
    logic            s_flush;
    logic            s_xfer;
    logic [BITS-1:0] s_popdata;

    assign p_read_empty = (head == tail) || stall;

    fifo_read_stream #(.BITS(BITS), .CNT_BITS(CNT)) dut (
        .read_clk    (read_clk),
        .read_rst_n  (read_rst_n),
        .p_read_en   (p_read_en),
        .p_read_data (p_read_data),
        .p_read_empty(p_read_empty),
        .flush       (flush),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .occupancy   (occupancy),
        .word_count  (word_count)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    always @(posedge read_clk) begin
        if (p_read_en && !p_read_empty) begin
            p_read_data <= mem[head % 1024];
            head        <= head + 1;
        end
    end

    function automatic int exp_occ();
        int n = 0;
        foreach (mq[i]) if (mq[i].vis <= cyc) n++;
        return n;
    endfunction

    function automatic bit exp_valid();
        return read_rst_n && !flush && (exp_occ() > 0);
    endfunction

    function automatic bit exp_en();
        return read_rst_n && !p_read_empty && !flush && (mq.size() < 3);
    endfunction

    always @(negedge read_clk) begin
        s_pop     = p_read_en && !p_read_empty;
        s_popdata = mem[head % 1024];
        s_flush   = flush;
        s_xfer    = exp_valid() && m_ready;
    end

    always @(posedge read_clk) begin
        cyc = cyc + 1;
        if (!read_rst_n) begin
            mq.delete();
            cnt = 0;
        end else begin
            if (s_flush) begin
                mq.delete();
            end else if (s_xfer) begin
                void'(mq.pop_front());
                cnt++;
            end
            if (s_pop) mq.push_back('{d: s_popdata, vis: cyc + 1});
        end
    end

    task automatic tick();
        @(posedge read_clk);
        #2;
    endtask

    task automatic push(input logic [BITS-1:0] w);
        mem[tail % 1024] = w;
        tail++;
    endtask

    task automatic drain();
        int n = 0;
        m_ready = 1'b1;
        stall   = 1'b0;
        flush   = 1'b0;
        while (!((head == tail) && (mq.size() == 0)) && n < 200) begin
            tick();
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: fifo_left=%0d model_left=%0d required 0/0", tail - head, mq.size());
        end
    endtask

    task automatic test_reset();
        read_rst_n = 1'b1;
        m_ready    = 1'b0;
        flush      = 1'b0;
        stall      = 1'b0;
        #1 read_rst_n = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h100 + i);
        repeat (3) tick();
        #1;
        checks++; if (p_read_en !== 1'b0) begin errors++; $display("FAIL reset_pop: got %b want 0", p_read_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", word_count); end
        tick();
        read_rst_n = 1'b1;
        #1;
        checks++; if (p_read_en !== 1'b1) begin errors++; $display("FAIL release_pop: got %b want 1", p_read_en); end
        drain();
    endtask

    task automatic test_single();
        int pop_cyc = -1;
        int val_cyc = -1;
        int nvalid  = 0;
        int c0;
        tick();
        c0 = cnt;
        push(32'hA5A50001);
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            if (p_read_en && pop_cyc < 0) pop_cyc = cyc;
            if (m_valid) begin
                nvalid++;
                if (val_cyc < 0) val_cyc = cyc;
                checks++;
                if (m_data !== 32'hA5A50001) begin errors++; $display("FAIL single_data: got %h want a5a50001", m_data); end
            end
            tick();
            #1;
        end
        checks++; if (val_cyc - pop_cyc !== 2) begin errors++; $display("FAIL single_latency: got %0d want 2", val_cyc - pop_cyc); end
        checks++; if (nvalid !== 1) begin errors++; $display("FAIL single_valid_cycles: got %0d want 1", nvalid); end
        checks++; if (word_count !== CNT'(c0 + 1)) begin errors++; $display("FAIL single_count: got %0d want %0d", word_count, CNT'(c0 + 1)); end
        checks++; if (p_read_en !== 1'b0) begin errors++; $display("FAIL single_idle_pop: got %b want 0", p_read_en); end
    endtask

    task automatic test_stream();
        int idx = 0;
        int gap = 0;
        int c0;
        tick();
        c0 = cnt;
        for (int i = 0; i < 16; i++) push(BITS'(i));
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== BITS'(idx)) begin errors++; $display("FAIL stream_data: got %h want %h", m_data, BITS'(idx)); end
                idx++;
            end else if (idx > 0 && idx < 16) begin
                gap++;
            end
            tick();
            #1;
        end
        checks++; if (idx !== 16) begin errors++; $display("FAIL stream_words: got %0d want 16", idx); end
        checks++; if (gap !== 0) begin errors++; $display("FAIL stream_bubbles: got %0d want 0", gap); end
        checks++; if (word_count !== CNT'(c0 + 16)) begin errors++; $display("FAIL stream_count: got %0d want %0d", word_count, CNT'(c0 + 16)); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL stream_occ_end: got %0d want 0", occupancy); end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int unstable = 0;
        int idx = 0;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(BITS'(i));
        #1;
        for (int i = 0; i < 10; i++) begin
            if (p_read_en) pops++;
            if (m_valid && m_data !== '0) unstable++;
            tick();
            #1;
        end
        checks++; if (pops !== 3) begin errors++; $display("FAIL bp_pops: got %0d want 3", pops); end
        checks++; if (occupancy !== 2'd3) begin errors++; $display("FAIL bp_occ: got %0d want 3", occupancy); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL bp_head: got %h want 0", m_data); end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable); end
        m_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (m_valid) begin
                checks++;
                if (m_data !== BITS'(idx)) begin errors++; $display("FAIL bp_data: got %h want %h", m_data, BITS'(idx)); end
                idx++;
            end
            tick();
            #1;
        end
        checks++; if (idx !== 8) begin errors++; $display("FAIL bp_words: got %0d want 8", idx); end
    endtask

    task automatic test_flush();
        bit found = 0;
        int c0;
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h200 + i);
        #1;
        for (int i = 0; i < 10 && !found; i++) begin
            if (exp_occ() == 2 && mq.size() == 3) found = 1;
            else begin tick(); #1; end
        end
        checks++; if (!found || occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup: occ got %0d want 2", occupancy); end
        c0 = cnt;
        flush = 1'b1;
        #1;
        checks++; if (p_read_en !== 1'b0) begin errors++; $display("FAIL flush_pop: got %b want 0", p_read_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", m_valid); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_valid_after: got %b want 0", m_valid); end
        checks++; if (word_count !== CNT'(c0)) begin errors++; $display("FAIL flush_count: got %0d want %0d", word_count, CNT'(c0)); end
        m_ready = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_valid) found = 1;
            else begin tick(); #1; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL flush_resume: no m_valid within 10 cycles, want data 00000203"); end
        else if (m_data !== 32'h203) begin errors++; $display("FAIL flush_resume: got %h want 00000203", m_data); end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            tick();
            m_ready = ($urandom_range(0, 9) < 7);
            stall   = ($urandom_range(0, 9) < 2);
            flush   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 9) < 6) push($urandom);
            #1;
            checks++; if (p_read_en !== exp_en()) begin errors++; $display("FAIL rand_pop: cyc %0d got %b want %b", cyc, p_read_en, exp_en()); end
            checks++; if (m_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, m_valid, exp_valid()); end
            checks++; if (occupancy !== 2'(exp_occ())) begin errors++; $display("FAIL rand_occ: cyc %0d got %0d want %0d", cyc, occupancy, exp_occ()); end
            checks++; if (word_count !== CNT'(cnt)) begin errors++; $display("FAIL rand_count: cyc %0d got %0d want %0d", cyc, word_count, CNT'(cnt)); end
            if (exp_valid()) begin
                checks++;
                if (m_data !== mq[0].d) begin errors++; $display("FAIL rand_data: cyc %0d got %h want %h", cyc, m_data, mq[0].d); end
            end
        end
        flush = 1'b0;
        stall = 1'b0;
        drain();
    endtask

    task automatic test_wrap_and_reset();
        bit found = 0;
        tick();
        read_rst_n = 1'b0;
        tick();
        tick();
        read_rst_n = 1'b1;
        for (int i = 0; i < 17; i++) push(32'h300 + i);
        m_ready = 1'b1;
        #1;
        for (int i = 0; i < 60 && cnt < 17; i++) begin tick(); #1; end
        checks++; if (word_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d want 1 after %0d transfers", word_count, cnt); end
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h400 + i);
        for (int i = 0; i < 10 && !found; i++) begin
            if (exp_occ() == 2) found = 1;
            else begin tick(); #1; end
        end
        checks++; if (!found || occupancy !== 2'd2) begin errors++; $display("FAIL rst_setup: occ got %0d want 2", occupancy); end
        read_rst_n = 1'b0;
        #1;
        checks++; if (p_read_en !== 1'b0) begin errors++; $display("FAIL rst_async_pop: got %b want 0", p_read_en); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %b want 0", m_valid); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL rst_async_occ: got %0d want 0", occupancy); end
        checks++; if (word_count !== '0) begin errors++; $display("FAIL rst_async_count: got %0d want 0", word_count); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL rst_async_data: got %h want 0", m_data); end
        tick();
        read_rst_n = 1'b1;
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_random();
        test_wrap_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
